// File: rtl/cim_layer_scheduler.sv
// Central sequencer for a chain of CIM layers: start pulse, busy handshake, func_start, drain.
// Define CIM_SCHED_PERF_CNT_EN to add the o_cycle_count / o_layer_cycles performance counters.
module cim_layer_scheduler #(
  parameter int unsigned num_layers     = 7,
  parameter int unsigned func_latency   = 4,
  parameter int unsigned timeout_cycles = 65535,
  parameter int unsigned cnt_width      = 16,
  localparam int unsigned lw            = (num_layers > 1) ? $clog2(num_layers) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_run,
  input  logic                  i_abort,
  input  logic [num_layers-1:0] i_busy,
  input  logic                  i_sink_busy,
  output logic [num_layers-1:0] o_start,
  output logic [num_layers-1:0] o_func_start,
  output logic [num_layers-1:0] o_next_busy,
  output logic [lw-1:0]         o_cur_layer,
  output logic                  o_active,
  output logic                  o_done,
  output logic                  o_error,
`ifdef CIM_SCHED_PERF_CNT_EN
  output logic [31:0]           o_cycle_count,
  output logic [31:0]           o_layer_cycles,
`endif
  output logic [lw-1:0]         o_err_layer
);

  localparam int unsigned dw = (func_latency > 1) ? $clog2(func_latency) : 1;
  localparam logic [num_layers-1:0] layer_one = num_layers'(1);
  localparam logic [cnt_width:0] wd_limit = (cnt_width + 1)'(timeout_cycles);

  typedef enum logic [2:0] {
    StIdle, StStart, StWaitHi, StWaitLo, StFunc, StDrain, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [lw-1:0]      layer_q, layer_d;
  logic [dw-1:0]      drain_q, drain_d;
  logic [cnt_width-1:0] wd_q, wd_d;
  logic [cnt_width:0] wd_inc;
  logic               active_q, active_d;
  logic               error_q, error_d;
  logic [lw-1:0]      err_layer_q, err_layer_d;
  logic               timeout;
  logic               last_layer;

  // Back-pressure is a pure rewiring of the downstream busy lines.
  if (num_layers > 1) begin : g_next_busy
    assign o_next_busy[num_layers-2:0] = i_busy[num_layers-1:1];
  end
  assign o_next_busy[num_layers-1] = i_sink_busy;

  assign wd_inc     = {1'b0, wd_q} + (cnt_width + 1)'(1);
  assign timeout    = (wd_inc == wd_limit);
  assign last_layer = (layer_q == lw'(num_layers - 1));

  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    drain_d      = drain_q;
    wd_d         = wd_q;
    active_d     = active_q;
    error_d      = error_q;
    err_layer_d  = err_layer_q;
    o_start      = '0;
    o_func_start = '0;
    o_done       = 1'b0;
    // Abort beats every other transition, including a timeout, and suppresses pulses.
    if (state_q != StIdle && i_abort) begin
      state_d  = StIdle;
      active_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_run) begin
            state_d  = StStart;
            layer_d  = '0;
            error_d  = 1'b0;
            active_d = 1'b1;
          end
        end
        StStart: begin
          o_start = layer_one << layer_q;
          wd_d    = '0;
          state_d = StWaitHi;
        end
        StWaitHi: begin
          if (i_busy[layer_q]) begin
            wd_d    = '0;
            state_d = StWaitLo;
          end else if (timeout) begin
            error_d     = 1'b1;
            err_layer_d = layer_q;
            active_d    = 1'b0;
            state_d     = StIdle;
          end else begin
            wd_d = wd_inc[cnt_width-1:0];
          end
        end
        StWaitLo: begin
          if (!i_busy[layer_q]) begin
            wd_d    = '0;
            state_d = StFunc;
          end else if (timeout) begin
            error_d     = 1'b1;
            err_layer_d = layer_q;
            active_d    = 1'b0;
            state_d     = StIdle;
          end else begin
            wd_d = wd_inc[cnt_width-1:0];
          end
        end
        StFunc: begin
          o_func_start = layer_one << layer_q;
          drain_d      = dw'(func_latency - 1);
          state_d      = StDrain;
        end
        StDrain: begin
          if (drain_q == '0) begin
            if (last_layer) begin
              state_d = StDone;
            end else begin
              layer_d = layer_q + lw'(1);
              state_d = StStart;
            end
          end else begin
            drain_d = drain_q - dw'(1);
          end
        end
        StDone: begin
          o_done   = 1'b1;
          active_d = 1'b0;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      layer_q     <= '0;
      drain_q     <= '0;
      wd_q        <= '0;
      active_q    <= 1'b0;
      error_q     <= 1'b0;
      err_layer_q <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      drain_q     <= drain_d;
      wd_q        <= wd_d;
      active_q    <= active_d;
      error_q     <= error_d;
      err_layer_q <= err_layer_d;
    end
  end

  assign o_cur_layer = layer_q;
  assign o_active    = active_q;
  assign o_error     = error_q;
  assign o_err_layer = err_layer_q;

`ifdef CIM_SCHED_PERF_CNT_EN
  logic [31:0] cyc_q;
  logic [31:0] lacc_q;
  logic [31:0] lcyc_q;

  // lacc counts the cycles from START up to, but not including, FUNC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      lacc_q <= '0;
      lcyc_q <= '0;
    end else begin
      if (state_q == StIdle && i_run) begin
        cyc_q <= '0;
      end else if (active_q && cyc_q != '1) begin
        cyc_q <= cyc_q + 32'd1;
      end
      if (state_q == StStart) begin
        lacc_q <= 32'd1;
      end else if ((state_q == StWaitHi || state_q == StWaitLo) && lacc_q != '1) begin
        lacc_q <= lacc_q + 32'd1;
      end
      if (state_q == StFunc && !i_abort) begin
        lcyc_q <= lacc_q;
      end
    end
  end

  assign o_cycle_count  = cyc_q;
  assign o_layer_cycles = lcyc_q;
`endif

endmodule

// File: tb/tb_cim_layer_scheduler.sv
// Self-checking bench for cim_layer_scheduler: event-time model of each run, per-cycle compare.
module tb_cim_layer_scheduler;

  localparam int NL   = 3;
  localparam int FL   = 4;
  localparam int TMO  = 20;
  localparam int MAXC = 310;
  localparam int P_ACT  = 0;
  localparam int P_LAY  = 1;
  localparam int P_ERR  = 2;
  localparam int P_ERRL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_run, i_abort, i_sink_busy;
  logic [NL-1:0] i_busy;
  logic [NL-1:0] o_start, o_func_start, o_next_busy;
  logic [1:0]    o_cur_layer, o_err_layer;
  logic          o_active, o_done, o_error;
`ifdef CIM_SCHED_PERF_CNT_EN
  logic [31:0]   cycle_count, layer_cycles;
`endif

  cim_layer_scheduler #(
    .num_layers    (NL),
    .func_latency  (FL),
    .timeout_cycles(TMO),
    .cnt_width     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_run        (i_run),
    .i_abort      (i_abort),
    .i_busy       (i_busy),
    .i_sink_busy  (i_sink_busy),
    .o_start      (o_start),
    .o_func_start (o_func_start),
    .o_next_busy  (o_next_busy),
    .o_cur_layer  (o_cur_layer),
    .o_active     (o_active),
    .o_done       (o_done),
    .o_error      (o_error),
`ifdef CIM_SCHED_PERF_CNT_EN
    .o_cycle_count (cycle_count),
    .o_layer_cycles(layer_cycles),
`endif
    .o_err_layer  (o_err_layer)
  );

  always #5 clk = ~clk;

  // Stimulus tables and expected outputs, indexed by cycle number.
  bit         run_tab[MAXC], abort_tab[MAXC], rst_tab[MAXC], sink_tab[MAXC];
  logic [2:0] busy_tab[MAXC], exp_start[MAXC], exp_func[MAXC];
  bit         exp_done[MAXC];
  int         pers[4][MAXC];
  int         dl[NL], hl[NL];
  int         n_chk, n_fail;
  bit         plan_done;
  int         done1, done2, done6, d_dummy;
  int         dut_done1, n_start1, n_func1, ord_bad, err_rise, n_done3;
  logic       prev_err;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic fill(input int which, input int from, input int v);
    for (int c = from; c < MAXC; c++) pers[which][c] = v;
  endtask

  task automatic chk(input int c, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  // Run accepted from cycle r; ab = abort cycle, rs = async-reset cycle (-1 when absent).
  task automatic plan_run(input int r, input int ab, input int rs, output int done_at);
    int  s, stop, rise, lo, fall, func, nxt;
    bit  ended, natural;
    stop    = (ab >= 0) ? ab : ((rs >= 0) ? rs : MAXC);
    s       = r + 1;
    done_at = -1;
    ended   = 0;
    natural = 0;
    run_tab[r] = 1;
    fill(P_ERR, s, 0);
    fill(P_ACT, s, 1);
    for (int k = 0; k < NL; k++) begin
      if (!ended) begin
        if (s >= stop) begin
          ended = 1;
        end else begin
          fill(P_LAY, s, k);
          exp_start[s] = 3'(1 << k);
          if (dl[k] < 0) begin
            ended = 1;
            if (s + TMO < stop) begin
              natural = 1;
              fill(P_ACT, s + TMO + 1, 0);
              fill(P_ERR, s + TMO + 1, 1);
              fill(P_ERRL, s + TMO + 1, k);
            end
          end else begin
            rise = s + dl[k];
            for (int c = rise; c < rise + hl[k] && c < MAXC; c++) busy_tab[c][k] = 1'b1;
            lo   = imax(rise, s + 1) + 1;
            fall = rise + hl[k];
            func = imax(fall, lo) + 1;
            if (func < stop) exp_func[func] = 3'(1 << k);
            nxt = func + 1 + FL;
            if (k == NL - 1) begin
              ended = 1;
              if (nxt < stop) begin
                natural = 1;
                done_at = nxt;
                exp_done[nxt] = 1;
                fill(P_ACT, nxt + 1, 0);
              end
            end else begin
              s = nxt;
            end
          end
        end
      end
    end
    if (!natural && ab >= 0) fill(P_ACT, ab + 1, 0);
    if (!natural && rs >= 0) begin
      fill(P_ACT, rs, 0);
      fill(P_LAY, rs, 0);
      fill(P_ERR, rs, 0);
      fill(P_ERRL, rs, 0);
    end
  endtask

  // Planner and driver: inputs change 1 time unit after the edge, reset 3 after.
  initial begin
    rst = 1'b1; i_run = 1'b0; i_abort = 1'b0; i_busy = '0; i_sink_busy = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      busy_tab[c]  = '0;
      exp_start[c] = '0;
      exp_func[c]  = '0;
      sink_tab[c]  = (c < 195 || c > 214) ? (((c * 5) >> 1) % 2 == 1) : 1'b0;
    end
    rst_tab[0] = 1; rst_tab[207] = 1; rst_tab[208] = 1;
    dl = '{2, 2, 2};  hl = '{10, 10, 10}; plan_run(5, -1, -1, done1);
    dl = '{2, 0, 1};  hl = '{3, 5, 2};    plan_run(70, -1, -1, done2);
    dl = '{1, 1, -1}; hl = '{2, 2, 0};    plan_run(110, -1, -1, d_dummy);
    dl = '{1, 2, 1};  hl = '{2, 20, 2};
    run_tab[175] = 1; abort_tab[180] = 1; plan_run(160, 180, -1, d_dummy);
    dl = '{1, 1, 1};  hl = '{2, 2, 2};    plan_run(200, -1, 207, d_dummy);
    dl = '{1, 3, 2};  hl = '{3, 4, 2};
    abort_tab[215] = 1;                   plan_run(215, -1, -1, done6);
    for (int c = 255; c <= 300; c++) begin
      busy_tab[c][1] = (c % 2 == 1);
      busy_tab[c][2] = ((c / 3) % 2 == 1);
    end
    plan_done = 1;
    for (int c = 0; c < MAXC; c++) begin
      @(posedge clk);
      #1;
      i_run       = run_tab[c];
      i_abort     = abort_tab[c];
      i_busy      = busy_tab[c];
      i_sink_busy = sink_tab[c];
      #2;
      rst = rst_tab[c];
    end
  end

  // Compare every cycle at the falling edge.
  initial begin
    n_chk = 0; n_fail = 0;
    dut_done1 = -1; n_start1 = 0; n_func1 = 0; ord_bad = 0; err_rise = -1; n_done3 = 0;
    prev_err = 1'b0;
    wait (plan_done);
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      chk(c, "start", o_start, exp_start[c]);
      chk(c, "func_start", o_func_start, exp_func[c]);
      chk(c, "done", o_done, exp_done[c]);
      chk(c, "active", o_active, pers[P_ACT][c]);
      chk(c, "cur_layer", o_cur_layer, pers[P_LAY][c]);
      chk(c, "error", o_error, pers[P_ERR][c]);
      chk(c, "err_layer", o_err_layer, pers[P_ERRL][c]);
      chk(c, "next_busy", o_next_busy, {sink_tab[c], busy_tab[c][2:1]});
      if (c < 65) begin
        if (o_start != '0) begin
          if (o_start != 3'(1 << n_start1)) ord_bad++;
          n_start1++;
        end
        if (o_func_start != '0) n_func1++;
        if (o_done === 1'b1 && dut_done1 < 0) dut_done1 = c;
      end
      if (c >= 105 && c < 160 && o_done === 1'b1) n_done3++;
      if (o_error === 1'b1 && prev_err !== 1'b1 && err_rise < 0) err_rise = c;
      prev_err = o_error;
`ifdef CIM_SCHED_PERF_CNT_EN
      if (c == 70) chk(c, "cycle_count", cycle_count, 32'd55);
`endif
    end
    chk(-1, "model_done_run1", done1, 60);
    chk(-1, "model_done_run2", done2, 102);
    chk(-1, "model_done_run6", done6, 249);
    chk(-1, "done_cycle_run1", dut_done1, 60);
    chk(-1, "start_count_run1", n_start1, 3);
    chk(-1, "start_order_run1", ord_bad, 0);
    chk(-1, "func_count_run1", n_func1, 3);
    chk(-1, "error_rise_cycle", err_rise, 150);
    chk(-1, "done_during_timeout", n_done3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
